debugger_scan: RTL and testbench
================================

Name: debugger_scan

Overview:
- Parametrised successor to the fixed 80x30 CPU debug-terminal generator.
- Continuously scans a character terminal, cell by cell, rendering prompts plus CPU PC, instruction, state, memory-bus and register-file values.
- Adds configurable geometry and register count, a per-frame consistent snapshot with freeze, a ready/write handshake toward the terminal, and frame status outputs.
- Sits between the CPU debug taps and the VGA terminal character RAM.

Parameters:
- COLUMNS, 80: terminal columns.
- ROWS, 30: terminal rows.
- ADDR_WIDTH, 12: terminal address width; ROWS*COLUMNS <= 2**ADDR_WIDTH.
- NUM_REGS, 32: registers displayed, taken from cpu_regs.
- REGS_PER_ROW, 5: register fields per display row.
- REG_FIELD_STRIDE, 16: column pitch of register fields; must be >= 8.
- REG_ROW_BASE, 8: first register row.
- STATE_WIDTH, 5: width of cpu_state.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cpu_pc  in  32  program counter.
- cpu_inst  in  32  current instruction.
- cpu_state  in  STATE_WIDTH  CPU FSM state.
- cpu_mem_write  in  1  memory write strobe.
- cpu_mem_addr  in  32  memory address.
- cpu_mem_read_data  in  32  memory read data.
- cpu_mem_write_data  in  32  memory write data.
- cpu_regs  in  32*NUM_REGS  register file; reg i = bits [32*i+31 : 32*i].
- freeze  in  1  hold the current snapshot at frame boundaries.
- terminal_ready  in  1  terminal accepts the presented cell this cycle.
- terminal_addr  out  ADDR_WIDTH  cell address (row*COLUMNS + column).
- terminal_write  out  1  cell valid.
- terminal_data  out  8  ASCII character.
- frame_done  out  1  one-cycle pulse after the last cell is accepted.
- frame_count  out  16  completed frames, wraps 0xFFFF -> 0.

Behaviour:
- Elaboration error if any of these fail:
  - REG_ROW_BASE + ceil(NUM_REGS/REGS_PER_ROW) <= ROWS.
  - REGS_PER_ROW*REG_FIELD_STRIDE <= COLUMNS.
  - COLUMNS >= 40.
  - ROWS >= 8.
- Reset values: terminal_addr=0, terminal_data=0, terminal_write=0, frame_done=0, frame_count=0, FSM=CAPTURE, snapshot=0.
- FSM, two states:
  - CAPTURE (1 cycle, terminal_write=0):
    - If freeze=0, latch all cpu_* inputs into the snapshot; if freeze=1, keep the snapshot unchanged.
    - Next cycle: SCAN, terminal_addr=0, terminal_data=char(0), terminal_write=1.
  - SCAN:
    - Accept = terminal_write & terminal_ready.
    - If not accepted, hold addr/data/write stable.
    - If accepted and addr < ROWS*COLUMNS-1: addr+1, data=char(addr+1), all registered on the same edge.
    - If accepted at the last cell: terminal_write=0, frame_done=1 next cycle, frame_count+1, go to CAPTURE.
- All rendering uses the snapshot only; input changes mid-frame never appear until the next CAPTURE.
- Layout, hex fields MSB nibble first, binary fields MSB bit first, digits uppercase 0-9 A-F:
  - Row 0: "PC:" at col 0; PC as 8 hex digits at col 8.
  - Row 1: "Inst:" at col 0; 32 binary digits at col 8.
  - Row 2: "State:" at col 0; STATE_WIDTH binary digits at col 8.
  - Row 3: "MWrite:" at col 0; 1 binary digit at col 8.
  - Rows 4/5/6: "MAddr:" / "MRData:" / "MWData:" at col 0; 8 hex digits at col 8.
  - Row 7: "Regs:" at col 0.
  - Reg i: row REG_ROW_BASE + i/REGS_PER_ROW, col (i%REGS_PER_ROW)*REG_FIELD_STRIDE, 8 hex digits.
  - Every other cell: 8'h00.
- Character encoding: hex digit d gives 8'h30+d for d<10, else 8'h37+d. Binary gives "0"/"1".
- Throughput with terminal_ready held at 1: one cell per cycle; frame period = ROWS*COLUMNS + 1 cycles.
- Reset asserted mid-frame: reset values on the next edge; the scan restarts at addr 0 after a fresh CAPTURE.
- frame_done and a CAPTURE never coincide with terminal_write=1.

Test Plan:
- Reset, then cpu_pc=0x00400010, ready=1 -> first write at addr 0 = "P" (0x50); addr 8..15 = "00400010"; frame_done at cycle 2401 after reset release; frame_count=1.
- Default params, cpu_regs reg 6 = 0xDEADBEEF -> cells 736..743 = "DEADBEEF"; reg 0 = 0x1 -> cells 640..647 = "00000001"; cell 8 of row 8 (addr 648) = 0x00.
- cpu_inst=0x80000001, cpu_state=5'b10010 -> addr 88 = "1", addr 119 = "1", addr 89..118 = "0"; addr 168..172 = "10010".
- terminal_ready toggled pseudo-randomly -> addr/data stable while ready=0; no cell skipped or duplicated; frame_done exactly once per 2400 accepts.
- freeze=1 before the second CAPTURE, cpu_pc changed to 0x12345678 -> the second frame still shows "00400010"; after freeze=0, the next frame shows "12345678".
- Reset pulsed at addr 1000; NUM_REGS=8, REGS_PER_ROW=4, ROWS=12 build -> reset values on the next edge, rescan from 0; reg 5 rendered at row 9, col 16.

Source files
------------

// File: rtl/debugger_scan.sv
// debugger_scan: scans a character terminal cell by cell and renders CPU debug
// state from a per-frame snapshot, with a ready/write handshake to the terminal.
module debugger_scan #(
  parameter int unsigned COLUMNS          = 80,
  parameter int unsigned ROWS             = 30,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned NUM_REGS         = 32,
  parameter int unsigned REGS_PER_ROW     = 5,
  parameter int unsigned REG_FIELD_STRIDE = 16,
  parameter int unsigned REG_ROW_BASE     = 8,
  parameter int unsigned STATE_WIDTH      = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              cpu_pc,
  input  logic [31:0]              cpu_inst,
  input  logic [STATE_WIDTH-1:0]   cpu_state,
  input  logic                     cpu_mem_write,
  input  logic [31:0]              cpu_mem_addr,
  input  logic [31:0]              cpu_mem_read_data,
  input  logic [31:0]              cpu_mem_write_data,
  input  logic [32*NUM_REGS-1:0]   cpu_regs,
  input  logic                     freeze,
  input  logic                     terminal_ready,
  output logic [ADDR_WIDTH-1:0]    terminal_addr,
  output logic                     terminal_write,
  output logic [7:0]               terminal_data,
  output logic                     frame_done,
  output logic [15:0]              frame_count
);

  localparam int unsigned CELLS    = ROWS * COLUMNS;
  localparam int unsigned REG_ROWS = (NUM_REGS + REGS_PER_ROW - 1) / REGS_PER_ROW;
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned COL_W    = $clog2(COLUMNS);

  // Fixed labels for rows 0..7, right-aligned in 64 bits, with their lengths.
  localparam logic [63:0] LBL [8] = '{
    64'("PC:"), 64'("Inst:"), 64'("State:"), 64'("MWrite:"),
    64'("MAddr:"), 64'("MRData:"), 64'("MWData:"), 64'("Regs:")
  };
  localparam int LBL_LEN [8] = '{3, 5, 6, 7, 6, 7, 7, 5};

  // Cell (0,0) is always the 'P' of the PC label, independent of the snapshot.
  localparam logic [7:0] FIRST_CHAR = 8'h50;

  // Geometry sanity checks at elaboration.
  if (REG_ROW_BASE + REG_ROWS > ROWS) begin : g_bad_reg_rows
    $error("debugger_scan: register rows do not fit in ROWS");
  end
  if (REGS_PER_ROW * REG_FIELD_STRIDE > COLUMNS) begin : g_bad_reg_cols
    $error("debugger_scan: register fields do not fit in COLUMNS");
  end
  if (COLUMNS < 40) begin : g_bad_columns
    $error("debugger_scan: COLUMNS must be >= 40");
  end
  if (ROWS < 8) begin : g_bad_rows
    $error("debugger_scan: ROWS must be >= 8");
  end
  if (REG_FIELD_STRIDE < 8) begin : g_bad_stride
    $error("debugger_scan: REG_FIELD_STRIDE must be >= 8");
  end
  if (REG_ROW_BASE < 8) begin : g_bad_reg_base
    $error("debugger_scan: register rows would overlap the fixed rows 0..7");
  end
  if (CELLS > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("debugger_scan: ROWS*COLUMNS exceeds the terminal address space");
  end

  typedef enum logic {
    CAPTURE = 1'b0,
    SCAN    = 1'b1
  } state_t;

  state_t                   state;
  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;

  logic [31:0]              snap_pc;
  logic [31:0]              snap_inst;
  logic [STATE_WIDTH-1:0]   snap_state;
  logic                     snap_mem_write;
  logic [31:0]              snap_mem_addr;
  logic [31:0]              snap_mem_read_data;
  logic [31:0]              snap_mem_write_data;
  logic [32*NUM_REGS-1:0]   snap_regs;

  logic [ROW_W-1:0]         next_row_c;
  logic [COL_W-1:0]         next_col_c;
  logic                     last_cell_c;
  logic [7:0]               next_char_c;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + 8'(d)) : (8'h37 + 8'(d));
  endfunction

  function automatic logic [7:0] bin_char(input logic b);
    return b ? 8'h31 : 8'h30;
  endfunction

  // Character for cell (r, c), taken only from the snapshot.
  function automatic logic [7:0] render_cell(input int r, input int c);
    logic [7:0] ch;
    int         k;
    int         off;
    int         idx;
    ch  = 8'h00;
    k   = c - 8;
    off = 0;
    idx = 0;
    if (r < 8) begin
      if (c < LBL_LEN[3'(r)]) begin
        ch = LBL[3'(r)][8*(LBL_LEN[3'(r)]-1-c) +: 8];
      end else begin
        case (r)
          0: if (k >= 0 && k < 8)  ch = hex_char(snap_pc[4*(7-k) +: 4]);
          1: if (k >= 0 && k < 32) ch = bin_char(snap_inst[31-k]);
          2: if (k >= 0 && k < int'(STATE_WIDTH))
               ch = bin_char(snap_state[int'(STATE_WIDTH)-1-k]);
          3: if (k == 0)           ch = bin_char(snap_mem_write);
          4: if (k >= 0 && k < 8)  ch = hex_char(snap_mem_addr[4*(7-k) +: 4]);
          5: if (k >= 0 && k < 8)  ch = hex_char(snap_mem_read_data[4*(7-k) +: 4]);
          6: if (k >= 0 && k < 8)  ch = hex_char(snap_mem_write_data[4*(7-k) +: 4]);
          default: ch = 8'h00;
        endcase
      end
    end else if (r >= int'(REG_ROW_BASE)) begin
      for (int f = 0; f < int'(REGS_PER_ROW); f++) begin
        off = c - f * int'(REG_FIELD_STRIDE);
        idx = (r - int'(REG_ROW_BASE)) * int'(REGS_PER_ROW) + f;
        if (off >= 0 && off < 8 && idx < int'(NUM_REGS)) begin
          ch = hex_char(snap_regs[32*idx + 4*(7-off) +: 4]);
        end
      end
    end
    return ch;
  endfunction

  // Next cell position and its character, used when the current cell is accepted.
  always_comb begin
    last_cell_c = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLUMNS - 1));
    next_row_c  = row_q;
    next_col_c  = col_q + COL_W'(1);
    if (col_q == COL_W'(COLUMNS - 1)) begin
      next_col_c = '0;
      next_row_c = row_q + ROW_W'(1);
    end
    next_char_c = render_cell(int'(next_row_c), int'(next_col_c));
  end

  // Capture/scan FSM with registered terminal outputs and snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= CAPTURE;
      row_q               <= '0;
      col_q               <= '0;
      terminal_addr       <= '0;
      terminal_data       <= 8'h00;
      terminal_write      <= 1'b0;
      frame_done          <= 1'b0;
      frame_count         <= 16'h0000;
      snap_pc             <= '0;
      snap_inst           <= '0;
      snap_state          <= '0;
      snap_mem_write      <= 1'b0;
      snap_mem_addr       <= '0;
      snap_mem_read_data  <= '0;
      snap_mem_write_data <= '0;
      snap_regs           <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        CAPTURE: begin
          if (!freeze) begin
            snap_pc             <= cpu_pc;
            snap_inst           <= cpu_inst;
            snap_state          <= cpu_state;
            snap_mem_write      <= cpu_mem_write;
            snap_mem_addr       <= cpu_mem_addr;
            snap_mem_read_data  <= cpu_mem_read_data;
            snap_mem_write_data <= cpu_mem_write_data;
            snap_regs           <= cpu_regs;
          end
          row_q          <= '0;
          col_q          <= '0;
          terminal_addr  <= '0;
          terminal_data  <= FIRST_CHAR;
          terminal_write <= 1'b1;
          state          <= SCAN;
        end
        SCAN: begin
          if (terminal_write && terminal_ready) begin
            if (last_cell_c) begin
              terminal_write <= 1'b0;
              frame_done     <= 1'b1;
              frame_count    <= frame_count + 16'd1;
              state          <= CAPTURE;
            end else begin
              row_q         <= next_row_c;
              col_q         <= next_col_c;
              terminal_addr <= terminal_addr + ADDR_WIDTH'(1);
              terminal_data <= next_char_c;
            end
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_debugger_scan.sv
// Directed bench for debugger_scan: default 80x30 build plus a 12-row, 8-register build.
module tb_debugger_scan;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic [31:0]       cpu_pc, cpu_inst, cpu_mem_addr, cpu_mem_read_data, cpu_mem_write_data;
  logic [4:0]        cpu_state;
  logic              cpu_mem_write;
  logic [32*32-1:0]  cpu_regs;
  logic              freeze, terminal_ready;

  logic [11:0]       terminal_addr;
  logic              terminal_write;
  logic [7:0]        terminal_data;
  logic              frame_done;
  logic [15:0]       frame_count;

  logic [11:0]       s_addr;
  logic              s_write;
  logic [7:0]        s_data;
  logic              s_done;
  logic [15:0]       s_count;

  debugger_scan dut (
    .clock(clock), .reset(reset),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_state(cpu_state),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_read_data(cpu_mem_read_data), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_regs(cpu_regs), .freeze(freeze), .terminal_ready(terminal_ready),
    .terminal_addr(terminal_addr), .terminal_write(terminal_write),
    .terminal_data(terminal_data), .frame_done(frame_done), .frame_count(frame_count)
  );

  debugger_scan #(.ROWS(12), .NUM_REGS(8), .REGS_PER_ROW(4)) dut_small (
    .clock(clock), .reset(reset),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_state(cpu_state),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_read_data(cpu_mem_read_data), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_regs(cpu_regs[32*8-1:0]), .freeze(freeze), .terminal_ready(terminal_ready),
    .terminal_addr(s_addr), .terminal_write(s_write),
    .terminal_data(s_data), .frame_done(s_done), .frame_count(s_count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] cells   [0:2399];
  logic [7:0] s_cells [0:959];
  int   exp_addr = 0, seq_err = 0, hold_err = 0, overlap_err = 0;
  int   accepts = 0, frames_seen = 0, stalls = 0;
  logic stall_pending = 1'b0;
  logic [11:0] stall_addr = '0;
  logic [7:0]  stall_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input int base, input string s);
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s@%0d", tag, base + i), 32'(cells[base + i]), 32'(s[i]));
  endtask

  task automatic check_sstr(input string tag, input int base, input string s);
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s@%0d", tag, base + i), 32'(s_cells[base + i]), 32'(s[i]));
  endtask

  // Passive monitor: records accepted cells, order, stall holds and frame_done.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_addr      = 0;
        stall_pending = 1'b0;
      end else begin
        if (stall_pending && (!terminal_write || terminal_addr != stall_addr ||
                              terminal_data != stall_data))
          hold_err++;
        stall_pending = terminal_write && !terminal_ready;
        if (stall_pending) begin
          stall_addr = terminal_addr;
          stall_data = terminal_data;
          stalls++;
        end
        if (terminal_write && terminal_ready) begin
          if (int'(terminal_addr) != exp_addr) seq_err++;
          if (terminal_addr < 12'd2400) cells[terminal_addr] = terminal_data;
          exp_addr = (exp_addr == 2399) ? 0 : exp_addr + 1;
          accepts++;
        end
        if (frame_done) begin
          frames_seen++;
          if (terminal_write) overlap_err++;
        end
        if (s_write && terminal_ready && s_addr < 12'd960) s_cells[s_addr] = s_data;
      end
    end
  end

  // Runs until frame_done (or budget); at cycle evt applies freeze/pc.
  task automatic run_frame(input int budget, input bit rnd, input int evt,
                           input logic evt_freeze, input logic [31:0] evt_pc,
                           input bit check_first, output int n, output bit done);
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clock);
      n++;
      #1;
      terminal_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == evt) begin
        freeze = evt_freeze;
        cpu_pc = evt_pc;
      end
      @(negedge clock);
      if (check_first && n == 1) begin
        check("first_write", 32'(terminal_write), 32'd1);
        check("first_addr", 32'(terminal_addr), 32'd0);
        check("first_data", 32'(terminal_data), 32'h50);
      end
      if (frame_done) begin
        done = 1'b1;
        check("done_no_write", 32'(terminal_write), 32'd0);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  32'(terminal_addr),  32'd0);
    check({tag, "_data"},  32'(terminal_data),  32'd0);
    check({tag, "_write"}, 32'(terminal_write), 32'd0);
    check({tag, "_done"},  32'(frame_done),     32'd0);
    check({tag, "_count"}, 32'(frame_count),    32'd0);
  endtask

  int n;
  bit done;

  initial begin
    reset              = 1'b1;
    freeze             = 1'b0;
    terminal_ready     = 1'b1;
    cpu_pc             = 32'h00400010;
    cpu_inst           = 32'h80000001;
    cpu_state          = 5'b10010;
    cpu_mem_write      = 1'b1;
    cpu_mem_addr       = 32'h0000ABCD;
    cpu_mem_read_data  = 32'h13579BDF;
    cpu_mem_write_data = 32'h2468ACE0;
    cpu_regs           = '0;
    cpu_regs[32*0  +: 32] = 32'h00000001;
    cpu_regs[32*5  +: 32] = 32'hCAFE0105;
    cpu_regs[32*6  +: 32] = 32'hDEADBEEF;
    cpu_regs[32*31 +: 32] = 32'h0123ABCD;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    check("reset_small_write", 32'(s_write), 32'd0);
    check("reset_small_count", 32'(s_count), 32'd0);

    // Frame 1: pc changes mid-frame and freeze is raised before the next capture.
    @(posedge clock);
    #1 reset = 1'b0;
    run_frame(3000, 1'b0, 100, 1'b1, 32'h12345678, 1'b1, n, done);
    check("frame1_latency", 32'(n), 32'd2401);
    check("frame1_count", 32'(frame_count), 32'd1);
    check("frame1_accepts", 32'(accepts), 32'd2400);
    check("frame1_order", 32'(seq_err), 32'd0);
    check_str("pc_label", 0, "PC:");
    check("pc_gap", 32'(cells[3]), 32'd0);
    check_str("pc_hex", 8, "00400010");
    check("pc_tail", 32'(cells[16]), 32'd0);
    check_str("inst_bits", 88, {"1", "0000000000", "0000000000", "0000000000", "1"});
    check_str("state_bits", 168, "10010");
    check_str("mwrite", 248, "1");
    check_str("maddr", 328, "0000ABCD");
    check_str("mrdata", 408, "13579BDF");
    check_str("mwdata_label", 480, "MWData:");
    check_str("mwdata", 488, "2468ACE0");
    check_str("regs_label", 560, "Regs:");
    check_str("reg0", 640, "00000001");
    check("reg_gap", 32'(cells[648]), 32'd0);
    check_str("reg6", 736, "DEADBEEF");
    check_str("reg31", 1136, "0123ABCD");
    check("small_count", 32'(s_count), 32'd2);
    check_sstr("small_reg0", 640, "00000001");
    check_sstr("small_reg5", 736, "CAFE0105");
    check("small_reg_gap", 32'(s_cells[744]), 32'd0);
    check("small_no_reg8", 32'(s_cells[800]), 32'd0);

    // Frame 2: random ready, snapshot frozen; freeze drops mid-frame.
    run_frame(20000, 1'b1, 50, 1'b0, 32'h12345678, 1'b0, n, done);
    check("frame2_done", 32'(done), 32'd1);
    check("frame2_count", 32'(frame_count), 32'd2);
    check("frame2_accepts", 32'(accepts), 32'd4800);
    check("frame2_done_pulses", 32'(frames_seen), 32'd2);
    check("frame2_order", 32'(seq_err), 32'd0);
    check("stall_hold", 32'(hold_err), 32'd0);
    check("stalls_seen", 32'(stalls != 0), 32'd1);
    check_str("frozen_pc", 8, "00400010");

    // Frame 3: fresh capture shows the new pc.
    run_frame(3000, 1'b0, 0, 1'b0, 32'h12345678, 1'b1, n, done);
    check("frame3_latency", 32'(n), 32'd2401);
    check("frame3_count", 32'(frame_count), 32'd3);
    check_str("new_pc", 8, "12345678");

    // Frame 4: reset at addr 1000, then a full rescan from addr 0.
    n = 0;
    while (terminal_addr != 12'd1000 && n < 3000) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check("reach_1000", 32'(terminal_addr), 32'd1000);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_state("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    run_frame(3000, 1'b0, 0, 1'b0, 32'h12345678, 1'b1, n, done);
    check("rescan_latency", 32'(n), 32'd2401);
    check("rescan_count", 32'(frame_count), 32'd1);
    check("rescan_order", 32'(seq_err), 32'd0);
    check_str("rescan_pc", 8, "12345678");
    check("done_overlap", 32'(overlap_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
